// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : AES-256 constants, FSM state type and GF(2^8) / S-box helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int NK = 8;
    localparam int NR = 14;

    typedef enum logic [0:0] {
        LOAD  = 1'b0,
        ROUND = 1'b1
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Padded to 16 entries so a 4-bit index covers the table exactly.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Word byte 0 sits at the LSB, so rotating left in FIPS terms is a right rotate here.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[7:0], w[31:8]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_step.sv
// ============================================================================
// aes_key_step : next four AES-256 key-schedule words from an 8-word window
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_key_step
    import aes_pkg::*;
(
    input  logic [32*NK-1:0] window,
    input  logic [3:0]       round,
    output logic [127:0]     next_words
);

    // Only the oldest four words and the newest word feed the recurrence.
    logic unused_words;
    assign unused_words = ^window[32*7-1:32*4];

    logic [3:0] rcon_idx;
    assign rcon_idx = (round + 4'd1) >> 1;

    always_comb begin
        logic [31:0] temp;
        next_words = '0;
        temp       = window[32*(NK-1) +: 32];
        for (int j = 0; j < 4; j++) begin
            // First new word of the step: odd rounds land on i mod 8 == 0, even on i mod 8 == 4.
            if (j == 0) begin
                if (round[0])
                    temp = sub_word(rot_word(temp)) ^ {24'h0, RCON[rcon_idx]};
                else
                    temp = sub_word(temp);
            end
            temp = window[32*j +: 32] ^ temp;
            next_words[32*j +: 32] = temp;
        end
    end

endmodule

`default_nettype wire

// File: rtl/encryption_top.sv
// ============================================================================
// encryption_top : free-running iterative AES-256 encryption, one round/clock
// Optional macro ENCRYPTIONTOP_DONE_EN adds a one-cycle done pulse. Revision: 1.0
// ============================================================================
`default_nettype none

module encryption_top
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] plaintext,
    input  logic [255:0] key_i,
    output logic [127:0] ciphertext
`ifdef ENCRYPTIONTOP_DONE_EN
    ,
    output logic         done
`endif
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t         fsm;
    logic [127:0]   aes_state;
    logic [255:0]   key_win;
    logic [3:0]     round;
    logic [127:0]   next_words;
    logic [127:0]   sb_sr;
    logic [127:0]   mixed;
    logic [127:0]   round_out;

    aes_key_step u_key_step (
        .window     (key_win),
        .round      (round),
        .next_words (next_words)
    );

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        sb_sr = '0;
        mixed = '0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        // SubBytes fused with ShiftRows: row r of column c takes column (c+r) mod 4.
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sb_sr[8*(4*c+r) +: 8] = sbox(aes_state[8*(4*((c+r)%4)+r) +: 8]);
        for (int c = 0; c < 4; c++) begin
            a0 = sb_sr[8*(4*c+0) +: 8];
            a1 = sb_sr[8*(4*c+1) +: 8];
            a2 = sb_sr[8*(4*c+2) +: 8];
            a3 = sb_sr[8*(4*c+3) +: 8];
            mixed[8*(4*c+0) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mixed[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mixed[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mixed[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        // The round key w[4r..4r+3] is the upper half of the window.
        round_out = ((round == LAST_ROUND) ? sb_sr : mixed) ^ key_win[255:128];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm        <= LOAD;
            aes_state  <= '0;
            key_win    <= '0;
            round      <= '0;
            ciphertext <= '0;
`ifdef ENCRYPTIONTOP_DONE_EN
            done       <= 1'b0;
`endif
        end else begin
`ifdef ENCRYPTIONTOP_DONE_EN
            done <= 1'b0;
`endif
            case (fsm)
                LOAD: begin
                    aes_state <= plaintext ^ key_i[127:0];
                    key_win   <= key_i;
                    round     <= 4'd1;
                    fsm       <= ROUND;
                end
                ROUND: begin
                    aes_state <= round_out;
                    key_win   <= {next_words, key_win[255:128]};
                    round     <= round + 4'd1;
                    if (round == LAST_ROUND) begin
                        ciphertext <= round_out;
                        fsm        <= LOAD;
`ifdef ENCRYPTIONTOP_DONE_EN
                        done       <= 1'b1;
`endif
                    end
                end
                default: fsm <= LOAD;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_encryption_top.sv
// ============================================================================
// tb_encryption_top : self-checking bench for encryption_top (vectors + model)
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_encryption_top;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] plaintext;
    logic [255:0] key_i;
    logic [127:0] ciphertext;
`ifdef ENCRYPTIONTOP_DONE_EN
    logic         done;
`endif

    always #5 clk = ~clk;

    encryption_top dut (
        .clk        (clk),
        .rst        (rst),
        .plaintext  (plaintext),
        .key_i      (key_i),
        .ciphertext (ciphertext)
`ifdef ENCRYPTIONTOP_DONE_EN
        ,
        .done       (done)
`endif
    );

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [127:0] pt;
        logic [255:0] key;
        logic [127:0] ct;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    logic [7:0] sb_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        logic       carry;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            carry = aa[7];
            aa    = aa << 1;
            if (carry) aa = aa ^ 8'h1b;
            bb    = bb >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            s = 8'h63;
            for (int sh = 0; sh < 5; sh++) s = s ^ 8'((inv << sh) | (inv >> (8 - sh)));
            sb_tab[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [255:0] key);
        logic [7:0] w [60][4];
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] tw [4];
        logic [7:0] x;
        logic [127:0] res;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
        for (int i = 8; i < 60; i++) begin
            for (int j = 0; j < 4; j++) tw[j] = w[i-1][j];
            if (i % 8 == 0) begin
                x = tw[0];
                tw[0] = sb_tab[tw[1]]; tw[1] = sb_tab[tw[2]];
                tw[2] = sb_tab[tw[3]]; tw[3] = sb_tab[x];
                tw[0] = tw[0] ^ 8'(1 << (i/8 - 1));
            end else if (i % 8 == 4) begin
                for (int j = 0; j < 4; j++) tw[j] = sb_tab[tw[j]];
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-8][j] ^ tw[j];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = pt[8*(4*c+r) +: 8] ^ w[c][r];
        for (int rnd = 1; rnd <= 14; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sb_tab[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 14) begin
                    s[0][c] = gmul(2, t[0][c]) ^ gmul(3, t[1][c]) ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ gmul(2, t[1][c]) ^ gmul(3, t[2][c]) ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ gmul(2, t[2][c]) ^ gmul(3, t[3][c]);
                    s[3][c] = gmul(3, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(2, t[3][c]);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][r];
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[8*(4*c+r) +: 8] = s[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        #1;
        check("reset_async_zero", ciphertext, '0);
        for (int k = 0; k < cycles; k++) begin
            plaintext = rand128();
            key_i     = {rand128(), rand128()};
            tick();
            check("reset_hold_zero", ciphertext, '0);
        end
    endtask

    // Reset, release and watch two full passes of one vector.
    task automatic run_vec(input vec_t v);
        do_reset(2);
        plaintext = v.pt;
        key_i     = v.key;
        rst       = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 14) check("edge14_still_zero", ciphertext, '0);
            if (e == 15 || e == 22 || e == 30) check("vector_ct", ciphertext, v.ct);
`ifdef ENCRYPTIONTOP_DONE_EN
            check("done_pulse", {127'h0, done}, {127'h0, (e == 15 || e == 30)});
`endif
        end
    endtask

    logic [127:0] pa, pb;
    logic [255:0] ka;
    logic [127:0] ea, eb;

    initial begin
        rst       = 1'b0;
        plaintext = '0;
        key_i     = '0;
        build_sbox();

        vecs[0] = '{pt: 128'hffeeddccbbaa99887766554433221100,
                    key: 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100,
                    ct: 128'h8960494b9049fceabf456751cab7a28e};
        vecs[1] = '{pt: 128'h0, key: 256'h0, ct: 128'h8720849214a248ad898940a278c095dc};
        for (int i = 2; i < NVEC; i++) begin
            vecs[i].pt  = rand128();
            vecs[i].key = {rand128(), rand128()};
            vecs[i].ct  = aes_model(vecs[i].pt, vecs[i].key);
        end

        tick();
        check("reset_initial_zero", ciphertext, '0);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

        // Reset asserted mid-pass (round 7 of the second pass).
        pa = rand128(); ka = {rand128(), rand128()}; ea = aes_model(pa, ka);
        do_reset(1);
        plaintext = pa; key_i = ka; rst = 1'b1;
        repeat (23) tick();
        check("midreset_before", ciphertext, ea);
        rst = 1'b0;
        #1;
        check("midreset_immediate_zero", ciphertext, '0);
        tick();
        check("midreset_held_zero", ciphertext, '0);
        rst = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (e == 14) check("midreset_edge14_zero", ciphertext, '0);
            if (e == 15) check("midreset_result", ciphertext, ea);
        end

        // Plaintext changed during round 5: current pass keeps old input.
        pa = rand128(); pb = rand128(); ka = {rand128(), rand128()};
        ea = aes_model(pa, ka); eb = aes_model(pb, ka);
        do_reset(1);
        plaintext = pa; key_i = ka; rst = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 6) plaintext = pb;
            if (e == 15 || e == 29) check("inchange_old_pass", ciphertext, ea);
            if (e == 30) check("inchange_new_pass", ciphertext, eb);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
